sbox_array: RTL
===============

// Module: sbox_array
// PURPOSE
//   Multi-lane AES byte-substitution unit with forward and inverse modes and a valid/ready handshake.
//   Each accepted word substitutes LANES bytes in parallel.
//   Serves SubBytes/InvSubBytes on a column (LANES=4) or full state (LANES=16), and SubWord in key expansion.
//   Per-transaction mode bit, so encrypt and decrypt traffic can interleave at full rate.
// PARAMETERS
//   LANES       4                 number of byte lanes substituted per transfer
//   OUT_REG     1                 1: extra output register stage (latency 2); 0: latency 1
//   SBOX_FILE   "../rtl/sbox.dat"  $readmemh image, forward S-box, 256 x 8b
//   ISBOX_FILE  "../rtl/isbox.dat" $readmemh image, inverse S-box, 256 x 8b
// PORTS
//   clk        in   1          single clock, all logic on posedge
//   rst        in   1          synchronous, active-high reset
//   in_valid   in   1          upstream word valid
//   in_ready   out  1          unit can accept this cycle
//   in_inv     in   1          0 = forward S-box, 1 = inverse S-box
//   in_data    in   8*LANES    lane i = in_data[8i+7:8i]
//   out_valid  out  1          result valid
//   out_ready  in   1          downstream accepts result
//   out_inv    out  1          mode bit carried with the result
//   out_data   out  8*LANES    lane i = S(in lane i) or S^-1(in lane i)
// BEHAVIOUR
//   - Transfer: a side fires when valid && ready on the same posedge. Upstream holds data and mode while stalled.
//   - Stage 1, lookup:
//       - synchronous ROM read with read enable; read only on input fire
//       - ROM output and s1_valid hold unchanged while stage 1 is stalled
//   - Stage 2 (OUT_REG=1): plain pipeline register; loads when it is empty or out_ready is high.
//   - in_ready = !s1_valid || s1_advance, where s1_advance is "stage 1 moves on this cycle".
//     Combinational from out_ready; no combinational path from in_valid.
//   - Latency: LATENCY = 1+OUT_REG cycles from input fire to out_valid, when there is no stall.
//   - Throughput: 1 word/cycle while out_ready=1. No bubbles on mode change between consecutive words.
//   - Capacity: LATENCY words in flight; with out_ready=0 it accepts exactly LATENCY words, then drops in_ready.
//   - Output stability: out_data/out_inv/out_valid stay stable while out_valid && !out_ready.
//   - Simultaneous fire in/out with the pipe full: accept, no loss, no duplication.
//   - Reset:
//       - all valid flags, out_data and out_inv go to 0
//       - in_ready = 1 the first cycle after rst deasserts
//       - rst mid-operation discards all in-flight words; nothing is emitted for them
//   - No arithmetic; pure table lookup. Lanes are independent; lane order is preserved.
//   - Both ROMs are read every fire; in_inv (registered alongside) selects the result.
// STRUCTURE
//   - Shared package/include aes_defs.vh:
//       - AES_BYTE=8
//       - default SBOX_FILE / ISBOX_FILE paths
//       - mode encodings AES_FWD=1'b0, AES_INV=1'b1
//   - Sub-module sbox_lane, instantiated LANES times via generate:
//       - ports: clk, en, inv, din[7:0] -> dout[7:0]
//       - holds both 256x8 ROMs; registered output with enable
//       - registered out_inv is kept in sbox_array
//   - Parent sbox_array owns the valid/ready control, the stage-2 register and the reset logic.
// TESTING
//   1. LANES=4, fwd, in_data=32'h0053FF01, out_ready=1
//      -> out_data=32'h63ED167C, out_inv=0, exactly LATENCY cycles later.
//   2. Inverse, in_data=32'h63ED167C -> out_data=32'h0053FF01, out_inv=1.
//      Back-to-back fwd/inv/fwd words -> 3 results on 3 consecutive cycles, correct per-word mode.
//   3. Stall: out_ready=0, stream 4 words
//      -> exactly LATENCY accepted, then in_ready=0; out_data stable.
//      Release out_ready -> all words out in order, no loss or duplication.
//   4. Random out_ready toggling, 10k random words and modes vs. golden model
//      -> bit-exact, in order; assert the out_valid && !out_ready stability property.
//   5. Assert rst for 1 cycle with 2 words in flight
//      -> next cycle out_valid=0, out_data=0, in_ready=1; no stale word emitted afterwards.
//   6. Exhaustive sweep of all 256 bytes in every lane, both modes, at OUT_REG=0 and 1
//      -> S^-1(S(x))=x and S(00)=63, S(FF)=16, S^-1(00)=52.

Source files
------------

// File: rtl/sbox_array_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : sbox_array_pkg                                                 |
// | Purpose  : Shared AES byte-substitution definitions: byte width, mode      |
// |            encodings and the forward / inverse S-box ROM images.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package sbox_array_pkg;

  localparam int   AES_BYTE = 8;
  localparam logic AES_FWD  = 1'b0;
  localparam logic AES_INV  = 1'b1;

  typedef logic [AES_BYTE-1:0] aes_byte_t;
  typedef aes_byte_t sbox_rom_t [256];

  // Forward AES S-box, indexed by input byte.
  localparam sbox_rom_t SBOX_ROM = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // The S-box is a permutation, so the inverse image is derived from the
  // forward one at elaboration; the two ROMs can never disagree.
  function automatic sbox_rom_t invert_rom(input sbox_rom_t fwd);
    sbox_rom_t inv;
    inv = '{default: '0};
    for (int i = 0; i < 256; i++) begin
      inv[fwd[i]] = aes_byte_t'(i);
    end
    return inv;
  endfunction

  localparam sbox_rom_t ISBOX_ROM = invert_rom(SBOX_ROM);

endpackage
`default_nettype wire

// File: rtl/sbox_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sbox_lane                                                       |
// | Purpose  : One byte lane: forward and inverse S-box ROMs with a shared     |
// |            registered read port and a mode select on the ROM outputs.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sbox_lane
  import sbox_array_pkg::*;
(
  input  logic       clk,
  input  logic       en,
  input  logic       inv,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  aes_byte_t r_fwd;
  aes_byte_t r_inv;

  // Synchronous read of both ROMs; contents hold while en is low (stall)
  always_ff @(posedge clk) begin
    if (en) begin
      r_fwd <= SBOX_ROM[din];
      r_inv <= ISBOX_ROM[din];
    end
  end

  // Pick the table matching the registered mode of the word in this stage
  always_comb begin
    dout = r_fwd;
    if (inv == AES_INV) begin
      dout = r_inv;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sbox_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sbox_array                                                      |
// | Purpose  : Multi-lane AES SubBytes / InvSubBytes with per-word mode and a  |
// |            valid/ready handshake; latency 1 + OUT_REG, 1 word per cycle.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sbox_array
  import sbox_array_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int OUT_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_inv,
  input  logic [8*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_inv,
  output logic [8*LANES-1:0]   out_data
);

  logic               r_s1_valid;
  logic               r_s1_inv;
  logic [8*LANES-1:0] w_s1_data;
  logic               w_in_fire;
  logic               w_s1_advance;

  // Ready depends only on pipeline state and out_ready, never on in_valid
  assign in_ready  = !r_s1_valid || w_s1_advance;
  assign w_in_fire = in_valid && in_ready;

  // Stage-1 occupancy and mode; the ROM data itself lives in the lanes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_inv   <= AES_FWD;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_inv   <= in_inv;
    end else if (w_s1_advance) begin
      r_s1_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sbox_lane u_lane (
      .clk  (clk),
      .en   (w_in_fire),
      .inv  (r_s1_inv),
      .din  (in_data[8*i +: 8]),
      .dout (w_s1_data[8*i +: 8])
    );
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic               r_s2_valid;
    logic               r_s2_inv;
    logic [8*LANES-1:0] r_s2_data;
    logic               w_s2_load;

    assign w_s2_load    = !r_s2_valid || out_ready;
    assign w_s1_advance = r_s1_valid && w_s2_load;

    // Output register: refills when empty or drained; payload only moves with a word
    always_ff @(posedge clk) begin
      if (rst) begin
        r_s2_valid <= 1'b0;
        r_s2_inv   <= AES_FWD;
        r_s2_data  <= '0;
      end else if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_inv  <= r_s1_inv;
          r_s2_data <= w_s1_data;
        end
      end
    end

    assign out_valid = r_s2_valid;
    assign out_inv   = r_s2_inv;
    assign out_data  = r_s2_data;
  end else begin : g_no_out_reg
    // The lane ROM registers have no reset, so the payload is masked
    // until a word is present to keep out_data at zero after reset.
    assign w_s1_advance = r_s1_valid && out_ready;
    assign out_valid    = r_s1_valid;
    assign out_inv      = r_s1_valid & r_s1_inv;
    assign out_data     = r_s1_valid ? w_s1_data : '0;
  end

endmodule
`default_nettype wire
